// File: rtl/joysync_neptuno_if.sv
// Joystick conditioning bus: raw decoder lines in, debounced levels, press
// pulses, 1 ms tick and menu request out. The block itself is the slave;
// the side driving the raw lines and consuming the results is the master.
interface joysync_neptuno_if;
   logic [7:0] joy1_raw_i;
   logic [7:0] joy2_raw_i;
   logic [7:0] joy1_o;
   logic [7:0] joy2_o;
   logic [7:0] joy1_press_o;
   logic [7:0] joy2_press_o;
   logic       tick_o;
   logic       menu_o;

   modport master (
      output joy1_raw_i, joy2_raw_i,
      input  joy1_o, joy2_o, joy1_press_o, joy2_press_o, tick_o, menu_o
   );

   modport slave (
      input  joy1_raw_i, joy2_raw_i,
      output joy1_o, joy2_o, joy1_press_o, joy2_press_o, tick_o, menu_o
   );
endinterface

// File: rtl/joysync_neptuno.sv
// Joystick line conditioner between the serial joystick decoder and the core.
// Re-times the 16 active-low raw lines into clk_i, debounces each bit on a
// 1 ms tick, emits one-cycle press pulses and raises a one-cycle menu request
// when joy1 START+FIRE3 stay held for HOLD_MS ticks.
//
// Menu combo FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | combo not held (debounced)
//   ST_COUNT | combo held, counting ticks in hcnt_q towards HOLD_MS
//   ST_FIRED | menu_o already pulsed for this hold, wait for release
module joysync_neptuno #(
   parameter int PRESC   = 48000,
   parameter int DEB_MS  = 4,
   parameter int HOLD_MS = 1000
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   joysync_neptuno_if.slave  js
);

   localparam int PW = $clog2(PRESC);
   localparam int CW = $clog2(DEB_MS + 1);
   localparam int HW = $clog2(HOLD_MS + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_MS - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FIRED = 2'd2
   } state_t;

   // bit order of all 16-bit vectors: [7:0] joy1, [15:8] joy2
   logic [15:0]   meta_q, meta_d;
   logic [15:0]   sync_q, sync_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic [15:0]   stable_q, stable_d;
   logic [CW-1:0] cnt_q [16];
   logic [CW-1:0] cnt_d [16];
   logic [15:0]   press_q, press_d;

   state_t        state_q;
   logic [HW-1:0] hcnt_q;
   logic          menu_q;
   logic          combo_held;

   // two-flop synchroniser; nothing else looks at the raw lines
   always_comb begin
      meta_d = {js.joy2_raw_i, js.joy1_raw_i};
      sync_d = meta_q;
   end

   // synchroniser stages reset to the released (high) level
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   // 1 ms prescaler; tick is registered so it is high while the count sits at PRESC-1
   always_comb begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      tick_d  = (presc_d == PRESC_LAST);
   end

   // prescaler and tick flops
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   // per-bit debounce: a bit is adopted only after DEB_MS consecutive ticks of
   // disagreement; any agreement in between clears the count so glitches never add up
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 16; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick_q) begin
            if (cnt_q[i] == DEB_LAST) begin
               stable_d[i] = sync_q[i];
               cnt_d[i]    = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      // press fires on the same edge the debounced level falls, so it lines up with joy*_o
      press_d = stable_q & ~stable_d;
   end

   // debounced levels, counters and press pulses
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stable_q <= '1;
         press_q  <= '0;
         for (int i = 0; i < 16; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         press_q  <= press_d;
         for (int i = 0; i < 16; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // START (bit 7) and FIRE3 (bit 6) of joy1, debounced, both pressed
   assign combo_held = ~stable_q[7] & ~stable_q[6];

   // menu combo FSM; hcnt saturates and FIRED blocks any repeat until release
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         hcnt_q  <= '0;
         menu_q  <= 1'b0;
      end else begin
         menu_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (combo_held) begin
                  state_q <= ST_COUNT;
                  hcnt_q  <= '0;
               end
            end
            ST_COUNT: begin
               if (!combo_held) begin
                  state_q <= ST_IDLE;
                  hcnt_q  <= '0;
               end else if (tick_q) begin
                  if (hcnt_q == HOLD_LAST) begin
                     menu_q  <= 1'b1;
                     state_q <= ST_FIRED;
                  end else if (hcnt_q != '1) begin
                     hcnt_q <= hcnt_q + HW'(1);
                  end
               end
            end
            ST_FIRED: begin
               if (!combo_held) begin
                  state_q <= ST_IDLE;
                  hcnt_q  <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               hcnt_q  <= '0;
            end
         endcase
      end
   end

   assign js.joy1_o       = stable_q[7:0];
   assign js.joy2_o       = stable_q[15:8];
   assign js.joy1_press_o = press_q[7:0];
   assign js.joy2_press_o = press_q[15:8];
   assign js.tick_o       = tick_q;
   assign js.menu_o       = menu_q;

endmodule

// File: tb/tb_joysync_neptuno.sv
// Bench for joysync_neptuno with PRESC=4, DEB_MS=3, HOLD_MS=5.
module tb_joysync_neptuno;

   localparam int PRESC   = 4;
   localparam int DEB     = 3;
   localparam int HOLD    = 5;
   localparam int LAT_MIN = 2 + (DEB - 1) * PRESC + 1;
   localparam int LAT_MAX = 2 + DEB * PRESC + 1;
   localparam int WAIT_LIM = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   joysync_neptuno_if js();

   joysync_neptuno #(.PRESC(PRESC), .DEB_MS(DEB), .HOLD_MS(HOLD)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .js      (js)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // waits until the chosen port's debounced output leaves 'old'; returns the
   // number of negedges taken and the OR of press/menu pulses seen meanwhile
   task automatic wait_change(input int port, input logic [7:0] old, output int n,
                              output logic [7:0] pseen, output logic mseen);
      logic [7:0] cur;
      n = 0; pseen = '0; mseen = 1'b0;
      do begin
         @(negedge clk);
         n++;
         pseen |= (port == 1) ? js.joy1_press_o : js.joy2_press_o;
         mseen |= js.menu_o;
         cur = (port == 1) ? js.joy1_o : js.joy2_o;
      end while (cur === old && n < WAIT_LIM);
   endtask

   task automatic test_reset();
      int n;
      js.joy1_raw_i = 8'hFF;
      js.joy2_raw_i = 8'hFF;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({js.joy1_o, js.joy2_o} !== 16'hFFFF)
         $display("FAIL reset_levels: got %h expected FFFF", {js.joy1_o, js.joy2_o});
      else passed++;
      checks++;
      if ({js.joy1_press_o, js.joy2_press_o, js.tick_o, js.menu_o} !== 18'h0)
         $display("FAIL reset_pulses: got %h expected 0",
                  {js.joy1_press_o, js.joy2_press_o, js.tick_o, js.menu_o});
      else passed++;
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (js.tick_o !== 1'b1 && n < 20);
      checks++;
      if (n != PRESC - 1)
         $display("FAIL first_tick: got %0d cycles expected %0d", n, PRESC - 1);
      else passed++;
      checks++;
      if ({js.joy1_o, js.joy2_o, js.joy1_press_o, js.joy2_press_o} !== 32'hFFFF_0000)
         $display("FAIL post_reset_idle: got %h expected FFFF0000",
                  {js.joy1_o, js.joy2_o, js.joy1_press_o, js.joy2_press_o});
      else passed++;
   endtask

   task automatic test_tick();
      int n;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (js.tick_o !== 1'b1 && n < 20);
         checks++;
         if (n != PRESC)
            $display("FAIL tick_period: got %0d expected %0d", n, PRESC);
         else passed++;
      end
   endtask

   task automatic test_single_press();
      int port, b, n;
      logic [7:0] mask, pseen, cur, pr;
      logic mseen;
      for (int it = 0; it < 4; it++) begin
         port = (it == 0) ? 1 : int'($urandom_range(1, 2));
         b    = (it == 0) ? 0 : int'($urandom_range(0, 7));
         mask = 8'h01 << b;
         @(negedge clk);
         if (port == 1) js.joy1_raw_i = ~mask; else js.joy2_raw_i = ~mask;
         wait_change(port, 8'hFF, n, pseen, mseen);
         cur = (port == 1) ? js.joy1_o : js.joy2_o;
         pr  = (port == 1) ? js.joy1_press_o : js.joy2_press_o;
         checks++;
         if (n < LAT_MIN || n > LAT_MAX)
            $display("FAIL press_latency: port %0d bit %0d got %0d clocks expected %0d..%0d",
                     port, b, n, LAT_MIN, LAT_MAX);
         else passed++;
         checks++;
         if (cur !== ~mask)
            $display("FAIL press_level: got %h expected %h", cur, ~mask);
         else passed++;
         checks++;
         if (pr !== mask)
            $display("FAIL press_pulse: got %h expected %h", pr, mask);
         else passed++;
         @(negedge clk);
         pr = (port == 1) ? js.joy1_press_o : js.joy2_press_o;
         checks++;
         if (pr !== 8'h00)
            $display("FAIL press_one_cycle: got %h expected 00", pr);
         else passed++;
         if (port == 1) js.joy1_raw_i = 8'hFF; else js.joy2_raw_i = 8'hFF;
         wait_change(port, ~mask, n, pseen, mseen);
         cur = (port == 1) ? js.joy1_o : js.joy2_o;
         checks++;
         if (cur !== 8'hFF || pseen !== 8'h00)
            $display("FAIL release_no_pulse: level %h press %h expected FF/00", cur, pseen);
         else passed++;
      end
   endtask

   task automatic test_glitch();
      int len, gap, b;
      logic bad;
      for (int g = 0; g < 6; g++) begin
         len = (g == 0) ? 6 : int'($urandom_range(1, 6));
         gap = int'($urandom_range(2, 6));
         b   = int'($urandom_range(0, 7));
         bad = 1'b0;
         @(negedge clk);
         js.joy2_raw_i = ~(8'h01 << b);
         repeat (len) begin
            @(negedge clk);
            if (js.joy2_o !== 8'hFF || js.joy2_press_o !== 8'h00) bad = 1'b1;
         end
         js.joy2_raw_i = 8'hFF;
         repeat (gap + 12) begin
            @(negedge clk);
            if (js.joy2_o !== 8'hFF || js.joy2_press_o !== 8'h00) bad = 1'b1;
         end
         checks++;
         if (bad)
            $display("FAIL glitch_adopted: len %0d bit %0d level %h press %h expected FF/00",
                     len, b, js.joy2_o, js.joy2_press_o);
         else passed++;
      end
      // back-to-back 6-clock glitches separated by 2 released clocks
      bad = 1'b0;
      for (int g = 0; g < 5; g++) begin
         js.joy2_raw_i = 8'hF7;
         repeat (6) begin
            @(negedge clk);
            if (js.joy2_o !== 8'hFF || js.joy2_press_o !== 8'h00) bad = 1'b1;
         end
         js.joy2_raw_i = 8'hFF;
         repeat (2) begin
            @(negedge clk);
            if (js.joy2_o !== 8'hFF || js.joy2_press_o !== 8'h00) bad = 1'b1;
         end
      end
      repeat (12) begin
         @(negedge clk);
         if (js.joy2_o !== 8'hFF || js.joy2_press_o !== 8'h00) bad = 1'b1;
      end
      checks++;
      if (bad)
         $display("FAIL glitch_train_adopted: level %h expected FF", js.joy2_o);
      else passed++;
   endtask

   task automatic test_multi();
      int n;
      logic [7:0] pseen;
      logic mseen;
      @(negedge clk);
      js.joy1_raw_i = 8'h00;
      js.joy2_raw_i = 8'h7F;
      wait_change(1, 8'hFF, n, pseen, mseen);
      checks++;
      if ({js.joy1_o, js.joy2_o} !== 16'h007F)
         $display("FAIL multi_levels: got %h expected 007F", {js.joy1_o, js.joy2_o});
      else passed++;
      checks++;
      if ({js.joy1_press_o, js.joy2_press_o} !== 16'hFF80)
         $display("FAIL multi_press: got %h expected FF80", {js.joy1_press_o, js.joy2_press_o});
      else passed++;
      @(negedge clk);
      checks++;
      if ({js.joy1_press_o, js.joy2_press_o} !== 16'h0000)
         $display("FAIL multi_press_one_cycle: got %h expected 0000",
                  {js.joy1_press_o, js.joy2_press_o});
      else passed++;
      js.joy1_raw_i = 8'hFF;
      js.joy2_raw_i = 8'hFF;
      wait_change(1, 8'h00, n, pseen, mseen);
      checks++;
      if ({js.joy1_o, js.joy2_o, pseen, js.joy2_press_o, mseen} !== {16'hFFFF, 16'h0000, 1'b0})
         $display("FAIL multi_release: levels %h press %h/%h menu %b expected FFFF/00/00/0",
                  {js.joy1_o, js.joy2_o}, pseen, js.joy2_press_o, mseen);
      else passed++;
   endtask

   // holds the combo and checks menu_o lands exactly one cycle after the
   // HOLD-th tick following adoption, and never again while held
   task automatic test_menu(input int rounds);
      int n, tk, pulses, bad;
      logic [7:0] pseen;
      logic mseen, armed, exp_m;
      for (int r = 0; r < rounds; r++) begin
         @(negedge clk);
         js.joy1_raw_i = 8'h3F;
         wait_change(1, 8'hFF, n, pseen, mseen);
         checks++;
         if (js.joy1_o !== 8'h3F || js.joy1_press_o !== 8'hC0)
            $display("FAIL combo_press: level %h press %h expected 3F/C0",
                     js.joy1_o, js.joy1_press_o);
         else passed++;
         tk = 0; pulses = 0; bad = 0; armed = 1'b0;
         for (int s = 0; s < 60; s++) begin
            @(negedge clk);
            exp_m = armed;
            armed = 1'b0;
            if (js.menu_o === 1'b1) pulses++;
            if (js.menu_o !== exp_m) bad++;
            if (js.tick_o === 1'b1) begin
               tk++;
               if (tk == HOLD) armed = 1'b1;
            end
         end
         checks++;
         if (bad != 0)
            $display("FAIL menu_timing: %0d wrong cycles, menu expected after tick %0d", bad, HOLD);
         else passed++;
         checks++;
         if (pulses != 1)
            $display("FAIL menu_count: got %0d pulses expected 1", pulses);
         else passed++;
         js.joy1_raw_i = 8'hFF;
         wait_change(1, 8'h3F, n, pseen, mseen);
         checks++;
         if (js.joy1_o !== 8'hFF || pseen !== 8'h00 || mseen !== 1'b0)
            $display("FAIL combo_release: level %h press %h menu %b expected FF/00/0",
                     js.joy1_o, pseen, mseen);
         else passed++;
      end
   endtask

   task automatic test_combo_abort();
      int n;
      logic [7:0] pseen;
      logic mseen, seen;
      @(negedge clk);
      js.joy1_raw_i = 8'h3F;
      wait_change(1, 8'hFF, n, pseen, mseen);
      seen = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         seen |= js.menu_o;
      end while (js.tick_o !== 1'b1 && n < 20);
      // released raw on the first counted tick: debounced release lands after the fourth
      js.joy1_raw_i = 8'hFF;
      wait_change(1, 8'h3F, n, pseen, mseen);
      seen |= mseen;
      repeat (20) begin
         @(negedge clk);
         seen |= js.menu_o;
      end
      checks++;
      if (seen !== 1'b0 || js.joy1_o !== 8'hFF)
         $display("FAIL combo_abort: menu %b level %h expected 0/FF", seen, js.joy1_o);
      else passed++;
      test_menu(1);
   endtask

   task automatic test_random_pattern();
      int n;
      logic [7:0] prev, pat, pseen;
      logic mseen;
      prev = 8'hFF;
      for (int it = 0; it < 7; it++) begin
         pat = (it == 6) ? 8'hFF : 8'($urandom);
         if (pat == prev) pat = pat ^ 8'h01;
         @(negedge clk);
         js.joy2_raw_i = pat;
         wait_change(2, prev, n, pseen, mseen);
         checks++;
         if (js.joy2_o !== pat || js.joy2_press_o !== (prev & ~pat) || js.joy1_o !== 8'hFF)
            $display("FAIL random_pattern: level %h press %h expected %h/%h",
                     js.joy2_o, js.joy2_press_o, pat, prev & ~pat);
         else passed++;
         checks++;
         if (n < LAT_MIN || n > LAT_MAX)
            $display("FAIL random_latency: got %0d expected %0d..%0d", n, LAT_MIN, LAT_MAX);
         else passed++;
         prev = pat;
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic bad;
      logic [7:0] pseen;
      logic mseen;
      @(negedge clk);
      js.joy1_raw_i = 8'h3F;
      wait_change(1, 8'hFF, n, pseen, mseen);
      js.joy2_raw_i = 8'h00;
      repeat (6) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({js.joy1_o, js.joy2_o, js.joy1_press_o, js.joy2_press_o, js.tick_o, js.menu_o}
          !== {16'hFFFF, 16'h0000, 2'b00})
         $display("FAIL async_reset: got %h expected FFFF0000 and pulses 0",
                  {js.joy1_o, js.joy2_o, js.joy1_press_o, js.joy2_press_o, js.tick_o, js.menu_o});
      else passed++;
      js.joy1_raw_i = 8'hFF;
      js.joy2_raw_i = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if ({js.joy1_o, js.joy2_o, js.joy1_press_o, js.joy2_press_o, js.menu_o}
             !== {16'hFFFF, 16'h0000, 1'b0}) bad = 1'b1;
      end
      checks++;
      if (bad)
         $display("FAIL reset_discard: progress or pulse seen after reset release");
      else passed++;
   endtask

   initial begin
      js.joy1_raw_i = 8'hFF;
      js.joy2_raw_i = 8'hFF;
      test_reset();
      test_tick();
      test_single_press();
      test_glitch();
      test_multi();
      test_menu(2);
      test_combo_abort();
      test_random_pattern();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, checks);
      $fatal(1, "watchdog");
   end

endmodule
